// File: rtl/imm_decode_pipe.sv
// ============================================================================
// Module   : imm_decode_pipe
// Function : RISC-V immediate decoder feeding a 2-entry skid buffer.
//            Compressed decode is enabled by the IMM_DECODE_RVC_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_decode_pipe #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic            i_signext,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_imm_type,
  output logic            o_illegal
);

  localparam logic [2:0] c_type_none  = 3'd0;
  localparam logic [2:0] c_type_i     = 3'd1;
  localparam logic [2:0] c_type_s     = 3'd2;
  localparam logic [2:0] c_type_b     = 3'd3;
  localparam logic [2:0] c_type_u     = 3'd4;
  localparam logic [2:0] c_type_j     = 3'd5;
  localparam logic [2:0] c_type_shamt = 3'd6;

  logic            w_s;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_shamt;
  logic [XLEN-1:0] w_imm;
  logic [2:0]      w_type;
  logic            w_ill;
  logic            w_shift;

  assign w_s     = i_instr[31] & i_signext;
  assign w_shift = (i_instr[13:12] == 2'b01);

  generate
    if (XLEN == 64) begin : g_xlen64
      assign w_imm_u     = {{(XLEN-32){w_s}}, i_instr[31:12], 12'b0};
      assign w_imm_shamt = {{(XLEN-6){1'b0}}, i_instr[25:20]};
    end else begin : g_xlen32
      assign w_imm_u     = {i_instr[31:12], 12'b0};
      assign w_imm_shamt = {{(XLEN-5){1'b0}}, i_instr[24:20]};
    end
  endgenerate

`ifdef IMM_DECODE_RVC_EN
  logic w_cs;
  assign w_cs = i_instr[12] & i_signext;
`endif

  always_comb begin
    w_imm  = '0;
    w_type = c_type_none;
    w_ill  = 1'b0;
    if (i_instr[1:0] != 2'b11) begin
`ifdef IMM_DECODE_RVC_EN
      case ({i_instr[15:13], i_instr[1:0]})
        5'b000_01, 5'b010_01: begin
          w_imm  = {{(XLEN-6){w_cs}}, i_instr[12], i_instr[6:2]};
          w_type = c_type_i;
        end
        5'b010_10: begin
          w_imm  = {{(XLEN-8){1'b0}}, i_instr[3:2], i_instr[12], i_instr[6:4], 2'b00};
          w_type = c_type_i;
        end
        5'b110_10: begin
          w_imm  = {{(XLEN-8){1'b0}}, i_instr[8:7], i_instr[12:9], 2'b00};
          w_type = c_type_s;
        end
        5'b101_01: begin
          w_imm  = {{(XLEN-12){w_cs}}, i_instr[12], i_instr[8], i_instr[10:9], i_instr[6],
                    i_instr[7], i_instr[2], i_instr[11], i_instr[5:3], 1'b0};
          w_type = c_type_j;
        end
        5'b110_01, 5'b111_01: begin
          w_imm  = {{(XLEN-9){w_cs}}, i_instr[12], i_instr[6:5], i_instr[2],
                    i_instr[11:10], i_instr[4:3], 1'b0};
          w_type = c_type_b;
        end
        default: w_ill = 1'b1;
      endcase
`else
      w_ill = 1'b1;
`endif
    end else begin
      case (i_instr[6:0])
        7'b0000011, 7'b1100111: begin
          w_imm  = {{(XLEN-12){w_s}}, i_instr[31:20]};
          w_type = c_type_i;
        end
        7'b0100011: begin
          w_imm  = {{(XLEN-12){w_s}}, i_instr[31:25], i_instr[11:7]};
          w_type = c_type_s;
        end
        7'b1100011: begin
          w_imm  = {{(XLEN-13){w_s}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
          w_type = c_type_b;
        end
        7'b1101111: begin
          w_imm  = {{(XLEN-21){w_s}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
          w_type = c_type_j;
        end
        7'b0110111, 7'b0010111: begin
          w_imm  = w_imm_u;
          w_type = c_type_u;
        end
        7'b0010011: begin
          if (w_shift) begin
            w_imm  = w_imm_shamt;
            w_type = c_type_shamt;
          end else begin
            w_imm  = {{(XLEN-12){w_s}}, i_instr[31:20]};
            w_type = c_type_i;
          end
        end
        7'b0011011: begin
          // Word-sized shifts only exist on RV64 and always carry a 5-bit amount.
          if (XLEN != 64) begin
            w_ill = 1'b1;
          end else if (w_shift) begin
            w_imm  = {{(XLEN-5){1'b0}}, i_instr[24:20]};
            w_type = c_type_shamt;
          end else begin
            w_imm  = {{(XLEN-12){w_s}}, i_instr[31:20]};
            w_type = c_type_i;
          end
        end
        default: w_ill = 1'b1;
      endcase
    end
  end

  logic            r_out_valid;
  logic [31:0]     r_out_instr;
  logic [XLEN-1:0] r_out_imm;
  logic [2:0]      r_out_type;
  logic            r_out_ill;
  logic            r_skid_valid;
  logic [31:0]     r_skid_instr;
  logic [XLEN-1:0] r_skid_imm;
  logic [2:0]      r_skid_type;
  logic            r_skid_ill;
  logic            w_xfer_in;
  logic            w_xfer_out;

  assign w_xfer_in  = i_valid & ~r_skid_valid;
  assign w_xfer_out = r_out_valid & i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid  <= 1'b0;
      r_out_instr  <= '0;
      r_out_imm    <= '0;
      r_out_type   <= c_type_none;
      r_out_ill    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= '0;
      r_skid_imm   <= '0;
      r_skid_type  <= c_type_none;
      r_skid_ill   <= 1'b0;
    end else if (i_flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_out_valid || w_xfer_out) begin
      // Output slot frees up: skid entry is older, so it goes first.
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_instr  <= r_skid_instr;
        r_out_imm    <= r_skid_imm;
        r_out_type   <= r_skid_type;
        r_out_ill    <= r_skid_ill;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_xfer_in;
        if (w_xfer_in) begin
          r_out_instr <= i_instr;
          r_out_imm   <= w_imm;
          r_out_type  <= w_type;
          r_out_ill   <= w_ill;
        end
      end
    end else if (w_xfer_in) begin
      r_skid_valid <= 1'b1;
      r_skid_instr <= i_instr;
      r_skid_imm   <= w_imm;
      r_skid_type  <= w_type;
      r_skid_ill   <= w_ill;
    end
  end

  assign o_ready    = ~r_skid_valid;
  assign o_valid    = r_out_valid;
  assign o_instr    = r_out_instr;
  assign o_imm      = r_out_imm;
  assign o_imm_type = r_out_type;
  assign o_illegal  = r_out_ill;

endmodule

`default_nettype wire

// File: tb/tb_imm_decode_pipe.sv
// ============================================================================
// Module   : tb_imm_decode_pipe
// Function : Directed self-checking bench for imm_decode_pipe (XLEN=32).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_decode_pipe;

  logic        clk = 1'b0;
  logic        i_rst, i_flush, i_valid, i_signext, i_ready;
  logic [31:0] i_instr;
  logic        o_ready, o_valid, o_illegal;
  logic [31:0] o_instr, o_imm;
  logic [2:0]  o_imm_type;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  imm_decode_pipe #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready), .i_instr(i_instr), .i_signext(i_signext),
    .o_valid(o_valid), .i_ready(i_ready), .o_instr(o_instr), .o_imm(o_imm),
    .o_imm_type(o_imm_type), .o_illegal(o_illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] imm, input logic [2:0] typ,
                         input logic ill);
    chk({tag, " valid"}, 64'(o_valid), 64'd1);
    chk({tag, " imm"}, 64'(o_imm), 64'(imm));
    chk({tag, " type"}, 64'(o_imm_type), 64'(typ));
    chk({tag, " illegal"}, 64'(o_illegal), 64'(ill));
  endtask

  task automatic push(input logic [31:0] instr);
    i_valid = 1'b1;
    i_instr = instr;
    tick();
  endtask

  initial begin
    i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_signext = 1'b1;
    i_ready = 1'b1; i_instr = 32'h0;
    tick(); tick();
    chk("rst valid", 64'(o_valid), 64'd0);
    chk("rst ready", 64'(o_ready), 64'd1);
    chk("rst imm", 64'(o_imm), 64'd0);
    chk("rst instr", 64'(o_instr), 64'd0);
    chk("rst type", 64'(o_imm_type), 64'd0);
    chk("rst illegal", 64'(o_illegal), 64'd0);
    i_rst = 1'b0;

    // Decode vectors, output draining every cycle.
    push(32'hFFC12083); chk_out("lw sext", 32'hFFFFFFFC, 3'd1, 1'b0);
    chk("lw instr", 64'(o_instr), 64'hFFC12083);
    i_signext = 1'b0;
    push(32'hFFC12083); chk_out("lw zext", 32'h00000FFC, 3'd1, 1'b0);
    i_signext = 1'b1;
    push(32'h123452B7); chk_out("lui", 32'h12345000, 3'd4, 1'b0);
    push(32'h00309093); chk_out("slli", 32'h00000003, 3'd6, 1'b0);
    push(32'h40505093); chk_out("srai", 32'h00000005, 3'd6, 1'b0);
    push(32'hFFF00093); chk_out("addi", 32'hFFFFFFFF, 3'd1, 1'b0);
    push(32'hFE512E23); chk_out("sw", 32'hFFFFFFFC, 3'd2, 1'b0);
    push(32'hFE000CE3); chk_out("beq neg", 32'hFFFFFFF8, 3'd3, 1'b0);
    push(32'h000000E3); chk_out("beq b7", 32'h00000800, 3'd3, 1'b0);
    push(32'h0010006F); chk_out("jal pos", 32'h00000800, 3'd5, 1'b0);
    push(32'hFFFFF06F); chk_out("jal neg", 32'hFFFFFFFE, 3'd5, 1'b0);
    push(32'h0000007F); chk_out("illegal", 32'h0, 3'd0, 1'b1);
`ifdef IMM_DECODE_RVC_EN
    push(32'h000050FD); chk_out("c.li", 32'hFFFFFFFF, 3'd1, 1'b0);
`else
    push(32'h000050FD); chk_out("c.li", 32'h0, 3'd0, 1'b1);
`endif
    i_valid = 1'b0;
    tick();
    chk("idle valid", 64'(o_valid), 64'd0);

    // Backpressure: A to output, B to skid, C held upstream.
    i_ready = 1'b0;
    push(32'h00100093);
    chk("stall A ready", 64'(o_ready), 64'd1);
    push(32'h00200093);
    chk("stall B ready", 64'(o_ready), 64'd0);
    push(32'h00300093);
    chk("stall C held", 64'(o_instr), 64'h00100093);
    chk("stall C ready", 64'(o_ready), 64'd0);
    i_ready = 1'b1;
    chk("drain A", 64'(o_instr), 64'h00100093);
    tick();
    chk("drain B", 64'(o_instr), 64'h00200093);
    chk("drain B imm", 64'(o_imm), 64'd2);
    tick();
    chk("drain C", 64'(o_instr), 64'h00300093);
    chk("drain C imm", 64'(o_imm), 64'd3);
    i_valid = 1'b0;
    tick();
    chk("drain empty", 64'(o_valid), 64'd0);

    // Flush with both entries buffered and a new word offered.
    i_ready = 1'b0;
    push(32'h00100093);
    push(32'h00200093);
    i_flush = 1'b1; i_instr = 32'h00300093; i_valid = 1'b1;
    tick();
    i_flush = 1'b0; i_valid = 1'b0;
    chk("flush valid", 64'(o_valid), 64'd0);
    chk("flush ready", 64'(o_ready), 64'd1);
    i_ready = 1'b1;
    tick();
    chk("flush dropped", 64'(o_valid), 64'd0);

    // Same with reset, also asserting flush to exercise priority.
    i_ready = 1'b0;
    push(32'h00100093);
    push(32'h00200093);
    i_rst = 1'b1; i_flush = 1'b1; i_instr = 32'h00300093; i_valid = 1'b1;
    tick();
    i_rst = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
    chk("rst2 valid", 64'(o_valid), 64'd0);
    chk("rst2 ready", 64'(o_ready), 64'd1);
    chk("rst2 imm", 64'(o_imm), 64'd0);
    i_ready = 1'b1;
    tick();
    chk("rst2 dropped", 64'(o_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imm_decode_pipe.md
IMM_DECODE_PIPE -- requirements
Module: imm_decode_pipe

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: i_clk (clock), i_rst (reset); both sampled and acting only on the rising edge of i_clk.
REQ-002 Parameters, one per line (name, default, meaning):
- XLEN, 32, datapath width; legal values 32 or 64.
REQ-003 Ports, one per line (name direction width meaning):
- i_clk input 1: clock.
- i_rst input 1: synchronous active-high reset.
- i_flush input 1: discard all buffered entries.
- i_valid input 1: upstream instruction valid.
- o_ready output 1: block can accept an instruction.
- i_instr input 32: instruction word.
- i_signext input 1: 1 means sign-extend immediates; 0 means zero-extend.
- o_valid output 1: output entry valid.
- i_ready input 1: downstream accepts output.
- o_instr output 32: instruction passed through.
- o_imm output XLEN: decoded immediate.
- o_imm_type output 3: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT.
- o_illegal output 1: opcode has no immediate decode.

Function
REQ-004 A transfer in SHALL occur on a cycle with i_valid and o_ready both high; a transfer out SHALL occur on a cycle with o_valid and i_ready both high.
REQ-005 Storage SHALL be an output register plus one skid register (2 entries); o_ready SHALL equal NOT skid_valid and SHALL be driven from registers only.
REQ-006 Latency SHALL be 1 cycle: an instruction accepted at edge N appears on the outputs after edge N when the output register is empty or drains at edge N.
REQ-007 If the output register is full and does not drain, an accepted instruction SHALL go to the skid register. When the output drains, the skid entry SHALL move to the output register on the same edge.
REQ-008 Ordering SHALL be strictly FIFO; no entry SHALL be lost or duplicated under any i_ready pattern.
REQ-009 Simultaneous transfer in and out with only the output register full SHALL replace the output entry directly, leaving the skid register empty.
REQ-010 Decode SHALL happen before storage (registered results). Let s = i_instr[31] AND i_signext, replicated to XLEN.
- Opcode 0000011, 1100111: I-type, sext(instr[31:20]).
- Opcode 0100011: S-type, sext({instr[31:25],instr[11:7]}).
- Opcode 1100011: B-type, sext({instr[31],instr[7],instr[30:25],instr[11:8],0}).
- Opcode 1101111: J-type, sext({instr[31],instr[19:12],instr[20],instr[30:21],0}).
- Opcode 0110111, 0010111: U-type, {instr[31:12],12'b0}, sign-extended with s to XLEN when XLEN=64.
- Opcode 0010011: if funct3 is 001 or 101, SHAMT type, zero-extended shamt = instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64); otherwise I-type.
- Opcode 0011011 (XLEN=64 only): same as 0010011, with a 5-bit shamt.
REQ-011 Bit 31 of the sign source SHALL be the instruction's MSB in the immediate field for every type (B uses instr[31], not instr[7]).
REQ-012 Any other opcode SHALL give o_imm=0, o_imm_type=NONE, o_illegal=1; outputs SHALL never be X.
REQ-013 i_flush SHALL clear both valid bits at the next edge and SHALL take priority over a transfer in on the same cycle; o_ready SHALL be 1 on the following cycle.

Reset
REQ-014 While i_rst is high at an edge, both valid bits SHALL clear: o_valid=0 and o_ready=1 from the next cycle. o_imm, o_instr and o_imm_type SHALL be 0 and o_illegal SHALL be 0.
REQ-015 Reset mid-stall SHALL discard buffered entries; reset SHALL take priority over i_flush and over any transfer.

Configuration
REQ-016 Macro IMM_DECODE_RVC_EN: when defined, words with i_instr[1:0]!=11 SHALL be decoded as 16-bit compressed using i_instr[15:0]:
- C.ADDI and C.LI: I, sext({b12,b6:2}).
- C.LWSP: I, zext({b3:2,b12,b6:4,00}).
- C.SWSP: S, zext({b8:7,b12:9,00}).
- C.J: J, sext({b12,b8,b10:9,b6,b7,b2,b11,b5:3,0}).
- C.BEQZ and C.BNEZ: B, sext({b12,b6:5,b2,b11:10,b4:3,0}).
- All other compressed encodings: illegal.
REQ-017 Without IMM_DECODE_RVC_EN, any word with i_instr[1:0]!=11 SHALL be illegal (o_imm=0, type NONE).

Verification
REQ-018 i_instr=0xFFC12083, i_signext=1, i_ready=1 -> next cycle o_valid=1, o_imm=0xFFFFFFFC, type I. With i_signext=0 -> o_imm=0x00000FFC.
REQ-019 i_instr=0x123452B7 -> o_imm=0x12345000, type U. i_instr=0x00309093 -> o_imm=3, type SHAMT.
REQ-020 i_instr=0x0000007F -> o_illegal=1, o_imm=0, type NONE, o_valid=1.
REQ-021 Hold i_ready=0 and push A, B, C back-to-back -> o_ready=0 after B is accepted and C is held upstream; then i_ready=1 -> outputs A, B, C in consecutive cycles.
REQ-022 With two entries buffered, assert i_flush together with i_valid -> next cycle o_valid=0, o_ready=1, and the new instruction is dropped. Repeat with i_rst -> same result.
REQ-023 With IMM_DECODE_RVC_EN defined, C.LI x1,-1 (0x50FD) -> o_imm=0xFFFFFFFF, type I. Without the macro, the same word -> o_illegal=1.
